// File: rtl/stopwatch_time_core.sv
// rtl/stopwatch_time_core.sv - mm:ss timekeeping core with run, pause and per-field adjust
module stopwatch_time_core #(
    parameter int MAX_MIN = 59
) (
    input  logic       onehz_clk,
    input  logic       rst,
    input  logic       run,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [5:0] seconds,
    output logic [6:0] minutes,
    output logic       running,
    output logic       adjusting,
    output logic       wrap
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ADJ} state_t;

    state_t     state, state_nxt;
    logic       sec_max, min_max;
    logic [7:0] sec_inc, min_inc;
    logic [3:0] so_n, st_n, mo_n, mt_n;
    logic       wrap_n;

    // Binary views built from shifts so no divider or multiplier is inferred.
    assign seconds = ({2'b00, sec_tens} << 3) + ({2'b00, sec_tens} << 1) + {2'b00, sec_ones};
    assign minutes = ({3'b000, min_tens} << 3) + ({3'b000, min_tens} << 1) + {3'b000, min_ones};

    assign sec_max = (sec_tens == 4'd5) && (sec_ones == 4'd9);
    assign min_max = (minutes == 7'(MAX_MIN));

    always_comb begin
        state_nxt = state;
        if (adj)
            state_nxt = ADJ;
        else if (run)
            state_nxt = RUN;
        else if (state != IDLE)
            state_nxt = PAUSE;
    end

    // Field increments wrap locally; the RUN path adds the carry chain itself.
    always_comb begin
        sec_inc = {sec_tens, sec_ones + 4'd1};
        if (sec_max)
            sec_inc = 8'h00;
        else if (sec_ones == 4'd9)
            sec_inc = {sec_tens + 4'd1, 4'd0};
    end

    always_comb begin
        min_inc = {min_tens, min_ones + 4'd1};
        if (min_max)
            min_inc = 8'h00;
        else if (min_ones == 4'd9)
            min_inc = {min_tens + 4'd1, 4'd0};
    end

    always_comb begin
        so_n   = sec_ones;
        st_n   = sec_tens;
        mo_n   = min_ones;
        mt_n   = min_tens;
        wrap_n = 1'b0;
        if (state == RUN && state_nxt == RUN) begin
            if (sec_max) begin
                so_n         = 4'd0;
                st_n         = 4'd0;
                {mt_n, mo_n} = min_inc;
                wrap_n       = min_max;
            end else begin
                {st_n, so_n} = sec_inc;
            end
        end else if (state == ADJ && adj) begin
            if (sel)
                {mt_n, mo_n} = min_inc;
            else
                {st_n, so_n} = sec_inc;
        end
    end

    always_ff @(posedge onehz_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sec_ones  <= 4'd0;
            sec_tens  <= 4'd0;
            min_ones  <= 4'd0;
            min_tens  <= 4'd0;
            running   <= 1'b0;
            adjusting <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_nxt;
            sec_ones  <= so_n;
            sec_tens  <= st_n;
            min_ones  <= mo_n;
            min_tens  <= mt_n;
            running   <= (state_nxt == RUN);
            adjusting <= (state_nxt == ADJ);
            wrap      <= wrap_n;
        end
    end

endmodule

// File: tb/tb_stopwatch_time_core.sv
// tb/tb_stopwatch_time_core.sv - randomized self-checking bench for stopwatch_time_core
module tb_stopwatch_time_core;

    logic       onehz_clk = 1'b0;
    logic       rst = 1'b1, run = 1'b0, adj = 1'b0, sel = 1'b0;
    logic [3:0] a_so, a_st, a_mo, a_mt, b_so, b_st, b_mo, b_mt;
    logic [5:0] a_seconds, b_seconds;
    logic [6:0] a_minutes, b_minutes;
    logic       a_running, a_adjusting, a_wrap, b_running, b_adjusting, b_wrap;

    int checks = 0;
    int errors = 0;

    // Model: state 0 idle, 1 run, 2 pause, 3 adjust; time kept as plain integers.
    int m_st[2], m_min[2], m_sec[2], m_wrap[2];
    int mmax[2] = '{59, 9};

    stopwatch_time_core #(.MAX_MIN(59)) dut_a (
        .onehz_clk(onehz_clk), .rst(rst), .run(run), .adj(adj), .sel(sel),
        .sec_ones(a_so), .sec_tens(a_st), .min_ones(a_mo), .min_tens(a_mt),
        .seconds(a_seconds), .minutes(a_minutes),
        .running(a_running), .adjusting(a_adjusting), .wrap(a_wrap)
    );

    stopwatch_time_core #(.MAX_MIN(9)) dut_b (
        .onehz_clk(onehz_clk), .rst(rst), .run(run), .adj(adj), .sel(sel),
        .sec_ones(b_so), .sec_tens(b_st), .min_ones(b_mo), .min_tens(b_mt),
        .seconds(b_seconds), .minutes(b_minutes),
        .running(b_running), .adjusting(b_adjusting), .wrap(b_wrap)
    );

    always #5 onehz_clk = ~onehz_clk;

    function automatic logic [31:0] exp_vec(int i);
        return {4'(m_min[i] / 10), 4'(m_min[i] % 10), 4'(m_sec[i] / 10), 4'(m_sec[i] % 10),
                7'(m_min[i]), 6'(m_sec[i]), m_st[i] == 1, m_st[i] == 3, m_wrap[i] != 0};
    endfunction

    function automatic logic [31:0] dut_vec(int i);
        if (i == 0)
            return {a_mt, a_mo, a_st, a_so, a_minutes, a_seconds, a_running, a_adjusting, a_wrap};
        return {b_mt, b_mo, b_st, b_so, b_minutes, b_seconds, b_running, b_adjusting, b_wrap};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_min[i] = 0; m_sec[i] = 0; m_wrap[i] = 0;
        end
    endtask

    task automatic model_step();
        int ns, t;
        for (int i = 0; i < 2; i++) begin
            ns = adj ? 3 : run ? 1 : (m_st[i] == 0) ? 0 : 2;
            m_wrap[i] = 0;
            if (m_st[i] == 1 && ns == 1) begin
                t = m_min[i] * 60 + m_sec[i] + 1;
                if (t == (mmax[i] + 1) * 60) begin
                    t = 0;
                    m_wrap[i] = 1;
                end
                m_min[i] = t / 60;
                m_sec[i] = t % 60;
            end else if (m_st[i] == 3 && adj) begin
                if (sel) m_min[i] = (m_min[i] + 1) % (mmax[i] + 1);
                else     m_sec[i] = (m_sec[i] + 1) % 60;
            end
            m_st[i] = ns;
        end
    endtask

    task automatic tick();
        @(posedge onehz_clk);
        if (rst) model_reset();
        else     model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b1;
        model_reset();
        tick(); tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dut_vec(i) !== exp_vec(i)) begin
                $display("FAIL reset dut%0d got %h exp %h", i, dut_vec(i), exp_vec(i)); errors++;
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_count();
        for (int n = 0; n < 62; n++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    $display("FAIL count dut%0d got %h exp %h", i, dut_vec(i), exp_vec(i)); errors++;
                end
            end
        end
        checks++;
        if (a_minutes !== 7'd1 || a_seconds !== 6'd1) begin
            $display("FAIL count_0101 got %0d:%0d exp 1:1", a_minutes, a_seconds); errors++;
        end
    endtask

    task automatic test_wrap();
        int n;
        run = 1'b0; adj = 1'b1; sel = 1'b1; n = 0;
        while (m_min[0] != 59 && n < 200) begin
            tick(); n++;
            checks++;
            if (dut_vec(0) !== exp_vec(0)) begin
                $display("FAIL wrap_preload got %h exp %h", dut_vec(0), exp_vec(0)); errors++;
            end
        end
        sel = 1'b0; n = 0;
        while (m_sec[0] != 58 && n < 200) begin
            tick(); n++;
        end
        checks++;
        if (a_minutes !== 7'd59 || a_seconds !== 6'd58) begin
            $display("FAIL wrap_5958 got %0d:%0d exp 59:58", a_minutes, a_seconds); errors++;
        end
        adj = 1'b0; run = 1'b1;
        tick(); tick();
        checks++;
        if (a_minutes !== 7'd59 || a_seconds !== 6'd59 || a_wrap !== 1'b0) begin
            $display("FAIL wrap_5959 got %0d:%0d w%b exp 59:59 w0", a_minutes, a_seconds, a_wrap); errors++;
        end
        tick();
        checks++;
        if (a_minutes !== 7'd0 || a_seconds !== 6'd0 || a_wrap !== 1'b1) begin
            $display("FAIL wrap_pulse got %0d:%0d w%b exp 0:0 w1", a_minutes, a_seconds, a_wrap); errors++;
        end
        tick();
        checks++;
        if (a_seconds !== 6'd1 || a_wrap !== 1'b0) begin
            $display("FAIL wrap_clear got s%0d w%b exp s1 w0", a_seconds, a_wrap); errors++;
        end
    endtask

    task automatic test_pause();
        #2 rst = 1'b1; #1 model_reset();
        checks++;
        if (dut_vec(0) !== exp_vec(0)) begin
            $display("FAIL async_reset got %h exp %h", dut_vec(0), exp_vec(0)); errors++;
        end
        rst = 1'b0; run = 1'b1;
        for (int n = 0; n < 6; n++) tick();
        run = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    $display("FAIL pause dut%0d got %h exp %h", i, dut_vec(i), exp_vec(i)); errors++;
                end
            end
        end
        checks++;
        if (a_seconds !== 6'd5 || a_running !== 1'b0) begin
            $display("FAIL pause_hold got s%0d r%b exp s5 r0", a_seconds, a_running); errors++;
        end
        run = 1'b1;
        tick();
        checks++;
        if (a_seconds !== 6'd5 || a_running !== 1'b1) begin
            $display("FAIL resume_entry got s%0d r%b exp s5 r1", a_seconds, a_running); errors++;
        end
        tick();
        checks++;
        if (a_seconds !== 6'd6) begin
            $display("FAIL resume_count got s%0d exp s6", a_seconds); errors++;
        end
    endtask

    task automatic test_adj();
        #2 rst = 1'b1; #1 model_reset();
        rst = 1'b0; run = 1'b1;
        for (int n = 0; n < 59; n++) tick();
        run = 1'b0; adj = 1'b1; sel = 1'b0;
        tick();
        checks++;
        if (a_seconds !== 6'd58 || a_adjusting !== 1'b1) begin
            $display("FAIL adj_entry got s%0d a%b exp s58 a1", a_seconds, a_adjusting); errors++;
        end
        tick(); tick();
        checks++;
        if (a_seconds !== 6'd0 || a_minutes !== 7'd0 || a_wrap !== 1'b0) begin
            $display("FAIL adj_sec_wrap got %0d:%0d w%b exp 0:0 w0", a_minutes, a_seconds, a_wrap); errors++;
        end
        sel = 1'b1;
        for (int n = 0; n < 60; n++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    $display("FAIL adj_min dut%0d got %h exp %h", i, dut_vec(i), exp_vec(i)); errors++;
                end
            end
        end
        checks++;
        if (a_minutes !== 7'd0) begin
            $display("FAIL adj_min_wrap got m%0d exp m0", a_minutes); errors++;
        end
    endtask

    task automatic test_priority_reset();
        int n;
        adj = 1'b1; run = 1'b1;
        tick();
        checks++;
        if (a_adjusting !== 1'b1 || a_running !== 1'b0) begin
            $display("FAIL priority got a%b r%b exp a1 r0", a_adjusting, a_running); errors++;
        end
        sel = 1'b1; n = 0;
        while (m_min[0] != 12 && n < 200) begin tick(); n++; end
        sel = 1'b0; n = 0;
        while (m_sec[0] != 34 && n < 200) begin tick(); n++; end
        checks++;
        if (a_minutes !== 7'd12 || a_seconds !== 6'd34) begin
            $display("FAIL preload_1234 got %0d:%0d exp 12:34", a_minutes, a_seconds); errors++;
        end
        #2 rst = 1'b1; #1 model_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dut_vec(i) !== exp_vec(i)) begin
                $display("FAIL adj_reset dut%0d got %h exp %h", i, dut_vec(i), exp_vec(i)); errors++;
            end
        end
        adj = 1'b0; run = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_max9();
        int n;
        adj = 1'b1; sel = 1'b1; n = 0;
        tick();
        while (m_min[1] != 9 && n < 200) begin tick(); n++; end
        sel = 1'b0; n = 0;
        while (m_sec[1] != 58 && n < 200) begin tick(); n++; end
        adj = 1'b0; run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    $display("FAIL max9 dut%0d got %h exp %h", i, dut_vec(i), exp_vec(i)); errors++;
                end
            end
            if (k == 2) begin
                checks++;
                if (b_wrap !== 1'b1 || b_minutes !== 7'd0 || b_mt !== 4'd0) begin
                    $display("FAIL max9_wrap got w%b m%0d mt%0d exp w1 m0 mt0", b_wrap, b_minutes, b_mt); errors++;
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            adj = ($urandom % 5) == 0;
            run = ($urandom % 4) != 0;
            sel = $urandom % 2;
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    $display("FAIL random dut%0d cyc%0d got %h exp %h", i, n, dut_vec(i), exp_vec(i)); errors++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_pause();
        test_adj();
        test_priority_reset();
        test_max9();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
